conv_frame_sequencer: RTL and testbench
=======================================

Name: conv_frame_sequencer

Overview:
Frame-level controller that sequences one conv_layer instance.
- Detects the start of an input frame and issues the layer's one-cycle start pulse.
- Meters exactly one frame of input words into the layer and forwards the layer's output vectors downstream.
- Counts outputs, pulses frame_done_o and re-arms the layer for the next frame, guaranteeing the idle cycle the layer needs between frames.

Parameters:
- INPUT_LAYER_HEIGHT, 64, input rows per frame
- KERNEL_HEIGHT, 5, kernel rows (must be <= INPUT_LAYER_HEIGHT-2)
- KERNEL_WIDTH, 2, kernel columns / words per row
- WORD_SIZE, 16, bits per word
- N_CONVOLUTIONS, 256, kernels in the controlled layer
- WATCHDOG_CYCLES, 1024, stall limit (watchdog build only)

Derived:
- IN_WORDS = KERNEL_WIDTH*INPUT_LAYER_HEIGHT
- OUT_VECS = INPUT_LAYER_HEIGHT-KERNEL_HEIGHT+1

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- valid_i  in  1  upstream word valid
- yumi_o  out  1  upstream word accepted
- data_i  in  WORD_SIZE  upstream word
- layer_start_o  out  1  start pulse to the layer
- layer_valid_o  out  1  word valid to the layer
- layer_yumi_i  in  1  layer accepted the word
- layer_data_o  out  WORD_SIZE  word to the layer (wired to data_i)
- layer_valid_i  in  1  layer output valid
- layer_ready_o  out  1  ready to the layer
- layer_data_i  in  N_CONVOLUTIONS*WORD_SIZE  layer output vector
- valid_o  out  1  downstream valid
- ready_i  in  1  downstream ready
- data_o  out  N_CONVOLUTIONS*WORD_SIZE  downstream vector (wired to layer_data_i)
- frame_done_o  out  1  one-cycle pulse at frame end
- busy_o  out  1  high in every state except eIDLE
- layer_reset_o  out  1  extra layer reset (watchdog build only)
- error_o  out  1  sticky watchdog error

Behaviour:

Reset:
- State eIDLE; in_cnt and out_cnt cleared.
- All outputs 0, except layer_data_o and data_o, which are combinational pass-throughs.

FSM states:
- eIDLE: waits for valid_i=1, then goes to eSTART next cycle. No word is consumed in eIDLE (yumi_o=0).
- eSTART: layer_start_o=1 for exactly this one cycle; yumi_o=0; always goes to eSTREAM.
- eSTREAM:
  - Input path, when in_cnt < IN_WORDS: layer_valid_o=valid_i, yumi_o=layer_yumi_i.
  - Input path, when in_cnt = IN_WORDS: layer_valid_o=0, yumi_o=0.
  - Output path: valid_o=layer_valid_i, layer_ready_o=ready_i.
  - in_cnt increments on valid_i&&layer_yumi_i; out_cnt increments on layer_valid_i&&ready_i.
  - Both increments may occur in the same cycle.
- eDRAIN:
  - Entered when in_cnt reaches IN_WORDS (registered count) and out_cnt < OUT_VECS.
  - Input path held at 0; output path as in eSTREAM.
- Transition to eDONE happens on the cycle after the OUT_VECS-th output handshake, provided in_cnt=IN_WORDS. This check is made from either eSTREAM or eDRAIN.
- eDONE:
  - frame_done_o=1 for one cycle; counters cleared; goes to eIDLE.
  - A valid_i held high restarts at eSTART no earlier than 2 cycles after eDONE. The layer therefore always spends at least one cycle in its ready state.

Counters:
- in_cnt width $clog2(IN_WORDS+1); out_cnt width $clog2(OUT_VECS+1).
- Neither counter wraps; both saturate at their terminal value.

Error handling:
- An output handshake with out_cnt already at OUT_VECS is not forwarded: valid_o is forced to 0.
- In eIDLE, layer_valid_i is ignored and layer_ready_o=0.

Reset mid-frame:
- Returns to eIDLE next cycle. error_o is cleared.
- The layer must be reset by the same reset_i.

Optional Feature:
CONV_SEQ_WATCHDOG_EN
- Defined:
  - A stall counter runs in eSTREAM and eDRAIN. It clears on any input or output handshake and also clears while a downstream-stalled output is pending (layer_valid_i&&!ready_i).
  - When it reaches WATCHDOG_CYCLES: layer_reset_o=1 for one cycle, error_o is set (sticky until reset_i), and the FSM goes to eIDLE without a frame_done_o pulse.
- Undefined: layer_reset_o and error_o are tied 0; no counter is generated; the ports remain present.

Test Plan:
Configuration for all scenarios: INPUT_LAYER_HEIGHT=8, KERNEL_HEIGHT=3, KERNEL_WIDTH=2, so IN_WORDS=16 and OUT_VECS=6.
1. Reset, then valid_i held 1 with the layer model always ready -> layer_start_o pulses once 1 cycle after valid_i rises; exactly 16 yumi_o pulses; 6 valid_o handshakes; one frame_done_o; busy_o back to 0.
2. Two back-to-back frames, valid_i never dropping -> second layer_start_o occurs at least 2 cycles after the first frame_done_o; 32 words in and 12 vectors out in total.
3. ready_i held 0 for 20 cycles mid-frame -> layer_ready_o=0 throughout; out_cnt frozen; no words lost; frame still completes with 6 outputs.
4. valid_i=1 for 17 words -> 17th word not consumed (yumi_o=0) until the next frame's eSTART has passed.
5. reset_i asserted after 7 input words -> next cycle busy_o=0 and counters are 0; a fresh frame completes normally with 16 in and 6 out.
6. Watchdog build, WATCHDOG_CYCLES=16, layer model stops asserting layer_yumi_i after 5 words -> layer_reset_o pulses on stall cycle 16; error_o=1 stays high; no frame_done_o.

Source files
------------

// File: rtl/conv_frame_sequencer_if.sv
// Handshake and data bundle between conv_frame_sequencer, its upstream source,
// the controlled conv_layer and the downstream sink. The slave side is the sequencer.
interface conv_frame_sequencer_if #(
  parameter int WORD_SIZE      = 16,
  parameter int N_CONVOLUTIONS = 256
);
  logic                                valid_i;
  logic                                yumi_o;
  logic [WORD_SIZE-1:0]                data_i;
  logic                                layer_valid_o;
  logic                                layer_yumi_i;
  logic [WORD_SIZE-1:0]                layer_data_o;
  logic                                layer_valid_i;
  logic                                layer_ready_o;
  logic [N_CONVOLUTIONS*WORD_SIZE-1:0] layer_data_i;
  logic                                valid_o;
  logic                                ready_i;
  logic [N_CONVOLUTIONS*WORD_SIZE-1:0] data_o;

  modport slave (
    input  valid_i, data_i, layer_yumi_i, layer_valid_i, layer_data_i, ready_i,
    output yumi_o, layer_valid_o, layer_data_o, layer_ready_o, valid_o, data_o
  );

  modport master (
    output valid_i, data_i, layer_yumi_i, layer_valid_i, layer_data_i, ready_i,
    input  yumi_o, layer_valid_o, layer_data_o, layer_ready_o, valid_o, data_o
  );
endinterface

// File: rtl/conv_frame_sequencer.sv
// Frame-level sequencer for one conv_layer: start pulse, input metering, output counting.
// Optional stall watchdog is enabled by defining CONV_SEQ_WATCHDOG_EN.
module conv_frame_sequencer #(
  parameter int INPUT_LAYER_HEIGHT = 64,
  parameter int KERNEL_HEIGHT      = 5,
  parameter int KERNEL_WIDTH       = 2,
  parameter int WORD_SIZE          = 16,
  parameter int N_CONVOLUTIONS     = 256,
  parameter int WATCHDOG_CYCLES    = 1024
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  conv_frame_sequencer_if.slave        bus,
  output logic                         layer_start_o,
  output logic                         frame_done_o,
  output logic                         busy_o,
  output logic                         layer_reset_o,
  output logic                         error_o
);
  localparam int IN_WORDS = KERNEL_WIDTH * INPUT_LAYER_HEIGHT;
  localparam int OUT_VECS = INPUT_LAYER_HEIGHT - KERNEL_HEIGHT + 1;
  localparam int IN_CW    = $clog2(IN_WORDS + 1);
  localparam int OUT_CW   = $clog2(OUT_VECS + 1);
  localparam logic [IN_CW-1:0]  IN_MAX  = IN_CW'(IN_WORDS);
  localparam logic [OUT_CW-1:0] OUT_MAX = OUT_CW'(OUT_VECS);

  if (KERNEL_HEIGHT > INPUT_LAYER_HEIGHT - 2 || WATCHDOG_CYCLES < 2 ||
      WORD_SIZE < 1 || N_CONVOLUTIONS < 1) begin : g_bad_cfg
    $error("conv_frame_sequencer: illegal parameter combination");
  end

  typedef enum logic [2:0] {eIDLE, eSTART, eSTREAM, eDRAIN, eDONE} state_e;

  state_e            state_q, state_d;
  logic [IN_CW-1:0]  in_cnt_q, in_cnt_d;
  logic [OUT_CW-1:0] out_cnt_q, out_cnt_d;
  logic              active, in_open, out_full, in_hs, out_hs, wd_trip;

  assign bus.layer_data_o = bus.data_i;
  assign bus.data_o       = bus.layer_data_i;

  always_comb begin
    active   = (state_q == eSTREAM) || (state_q == eDRAIN);
    in_open  = (state_q == eSTREAM) && (in_cnt_q != IN_MAX);
    out_full = (out_cnt_q == OUT_MAX);
    in_hs    = in_open && bus.valid_i && bus.layer_yumi_i;
    out_hs   = active && bus.layer_valid_i && bus.ready_i;
  end

  always_comb begin
    // NOTE: every output and next-state value gets a default first, so no path can infer a latch.
    state_d           = state_q;
    in_cnt_d          = in_cnt_q;
    out_cnt_d         = out_cnt_q;
    layer_start_o     = 1'b0;
    frame_done_o      = 1'b0;
    busy_o            = (state_q != eIDLE);
    bus.yumi_o        = 1'b0;
    bus.layer_valid_o = 1'b0;
    bus.layer_ready_o = 1'b0;
    bus.valid_o       = 1'b0;

    if (in_open) begin
      bus.layer_valid_o = bus.valid_i;
      bus.yumi_o        = bus.layer_yumi_i;
    end
    // A vector arriving after the frame quota is swallowed rather than forwarded.
    if (active) begin
      bus.valid_o       = bus.layer_valid_i && !out_full;
      bus.layer_ready_o = bus.ready_i;
    end
    if (in_hs)               in_cnt_d  = in_cnt_q + IN_CW'(1);
    if (out_hs && !out_full) out_cnt_d = out_cnt_q + OUT_CW'(1);

    unique case (state_q)
      eIDLE:   if (bus.valid_i) state_d = eSTART;
      eSTART: begin
        layer_start_o = 1'b1;
        state_d       = eSTREAM;
      end
      eSTREAM: if (in_cnt_q == IN_MAX) state_d = out_full ? eDONE : eDRAIN;
      eDRAIN:  if (out_full) state_d = eDONE;
      eDONE: begin
        frame_done_o = 1'b1;
        in_cnt_d     = '0;
        out_cnt_d    = '0;
        state_d      = eIDLE;
      end
      default: state_d = eIDLE;
    endcase

    if (wd_trip) begin
      state_d   = eIDLE;
      in_cnt_d  = '0;
      out_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset_i) begin
      state_q   <= eIDLE;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

`ifdef CONV_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);

  logic [WD_W-1:0] stall_q, stall_d;
  logic            error_q, error_d, stall_clr;

  // A downstream back-pressured output is the sink's fault, not a layer hang.
  always_comb begin
    stall_clr = in_hs || out_hs || (bus.layer_valid_i && !bus.ready_i);
    wd_trip   = active && !stall_clr && (stall_q == WD_LAST);
    stall_d   = (!active || stall_clr || wd_trip) ? '0 : stall_q + WD_W'(1);
    error_d   = error_q || wd_trip;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_q <= '0;
      error_q <= 1'b0;
    end else begin
      stall_q <= stall_d;
      error_q <= error_d;
    end
  end

  assign layer_reset_o = wd_trip;
  assign error_o       = error_q;
`else
  assign wd_trip       = 1'b0;
  assign layer_reset_o = 1'b0;
  assign error_o       = 1'b0;
`endif
endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Directed bench for conv_frame_sequencer with a small behavioural conv_layer model
// (8 rows, 3-row kernel, 2 words per row: 16 words in, 6 vectors out per frame).
module tb_conv_frame_sequencer;
  localparam int H  = 8;
  localparam int KH = 3;
  localparam int KW = 2;
  localparam int WS = 16;
  localparam int NC = 4;

  logic clk = 1'b0;
  logic reset_i;
  logic layer_start_o, frame_done_o, busy_o, layer_reset_o, error_o;

  conv_frame_sequencer_if #(.WORD_SIZE(WS), .N_CONVOLUTIONS(NC)) bus ();

  conv_frame_sequencer #(
    .INPUT_LAYER_HEIGHT(H), .KERNEL_HEIGHT(KH), .KERNEL_WIDTH(KW),
    .WORD_SIZE(WS), .N_CONVOLUTIONS(NC), .WATCHDOG_CYCLES(16)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .bus(bus),
    .layer_start_o(layer_start_o), .frame_done_o(frame_done_o), .busy_o(busy_o),
    .layer_reset_o(layer_reset_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Layer model: a row completes every KW words; each row from the KH-th on yields one vector.
  int m_words = 0;
  int m_outs  = 0;
  bit stall_mode = 1'b0;

  always @(posedge clk) begin
    if (reset_i || layer_start_o || layer_reset_o) begin
      m_words <= 0;
      m_outs  <= 0;
    end else begin
      if (bus.layer_valid_o && bus.layer_yumi_i) m_words <= m_words + 1;
      if (bus.layer_valid_i && bus.layer_ready_o) m_outs <= m_outs + 1;
    end
  end

  assign bus.layer_yumi_i  = bus.layer_valid_o && !(stall_mode && m_words >= 5);
  assign bus.layer_valid_i = ((m_words / KW) >= KH) && ((m_words / KW) - KH + 1 > m_outs);
  assign bus.layer_data_i  = {NC{16'hA000 + 16'(m_outs)}};

  // Monitor, sampled on the falling edge.
  int cyc = 0;
  int n_in = 0, n_out = 0, n_done = 0, n_start = 0, n_lrst = 0, n_err_cyc = 0;
  int bad_yumi = 0, bad_ready = 0;
  int last_yumi_cyc = 0, last_done_cyc = 0, last_start_cyc = 0, lrst_cyc = 0;
  logic [NC*WS-1:0] last_data = '0;

  assign bus.data_i = 16'h0100 + 16'(n_in);

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.yumi_o) begin
      n_in++;
      last_yumi_cyc = cyc;
      if (!busy_o || layer_start_o || frame_done_o) bad_yumi++;
    end
    if (bus.valid_o && bus.ready_i) begin
      n_out++;
      last_data = bus.data_o;
    end
    if (frame_done_o) begin
      n_done++;
      last_done_cyc = cyc;
    end
    if (layer_start_o) begin
      n_start++;
      last_start_cyc = cyc;
    end
    if (bus.layer_ready_o && (!bus.ready_i || !busy_o)) bad_ready++;
    if (layer_reset_o) begin
      n_lrst++;
      lrst_cyc = cyc;
    end
    if (error_o) n_err_cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (n_done >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    reset_i     = 1'b1;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [8:0] outs;
    reset_i     = 1'b1;
    bus.valid_i = 1'b1;
    bus.ready_i = 1'b1;
    tick();
    tick();
    outs = {bus.yumi_o, layer_start_o, bus.layer_valid_o, bus.layer_ready_o, bus.valid_o,
            frame_done_o, busy_o, layer_reset_o, error_o};
    checks++;
    if (outs !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", outs, 9'b0);
    end
    bus.valid_i = 1'b0;
    reset_i     = 1'b0;
    tick();
    tick();
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: got %b expected 0", busy_o);
    end
  endtask

  task automatic test_single_frame();
    int b_in = n_in, b_out = n_out, b_done = n_done, b_start = n_start;
    int b_by = bad_yumi, b_br = bad_ready;
    int k;
    bit ok;
    bus.ready_i = 1'b1;
    bus.valid_i = 1'b1;
    k = cyc;
    wait_done(b_done + 1, 200, ok);
    bus.valid_i = 1'b0;
    tick();
    tick();
    checks++;
    if (!ok) begin errors++; $display("FAIL single_timeout: no frame_done within 200 cycles"); end
    checks++;
    if (last_start_cyc !== k + 1) begin
      errors++;
      $display("FAIL single_start_latency: got %0d expected %0d", last_start_cyc - k, 1);
    end
    checks++;
    if (n_start - b_start !== 1) begin errors++; $display("FAIL single_starts: got %0d expected 1", n_start - b_start); end
    checks++;
    if (n_in - b_in !== 16) begin errors++; $display("FAIL single_words_in: got %0d expected 16", n_in - b_in); end
    checks++;
    if (n_out - b_out !== 6) begin errors++; $display("FAIL single_vecs_out: got %0d expected 6", n_out - b_out); end
    checks++;
    if (n_done - b_done !== 1) begin errors++; $display("FAIL single_done: got %0d expected 1", n_done - b_done); end
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b expected 0", busy_o); end
    checks++;
    if (last_data !== {NC{16'hA005}}) begin
      errors++;
      $display("FAIL single_last_data: got %h expected %h", last_data, {NC{16'hA005}});
    end
    checks++;
    if (bad_yumi - b_by !== 0 || bad_ready - b_br !== 0) begin
      errors++;
      $display("FAIL single_idle_handshake: got yumi %0d ready %0d expected 0 0", bad_yumi - b_by, bad_ready - b_br);
    end
  endtask

  task automatic test_back_to_back();
    int b_in = n_in, b_out = n_out, b_done = n_done, b_start = n_start;
    int gap;
    bit ok1, ok2, ok_s;
    bus.ready_i = 1'b1;
    bus.valid_i = 1'b1;
    wait_done(b_done + 1, 200, ok1);
    ok_s = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (n_start >= b_start + 2) begin ok_s = 1'b1; break; end
      tick();
    end
    gap = last_start_cyc - last_done_cyc;
    wait_done(b_done + 2, 200, ok2);
    bus.valid_i = 1'b0;
    tick();
    tick();
    checks++;
    if (!(ok1 && ok2 && ok_s)) begin
      errors++;
      $display("FAIL b2b_timeout: got done1=%0d start2=%0d done2=%0d expected 1 1 1", ok1, ok_s, ok2);
    end
    checks++;
    if (gap < 2) begin errors++; $display("FAIL b2b_restart_gap: got %0d expected >= 2", gap); end
    checks++;
    if (n_in - b_in !== 32) begin errors++; $display("FAIL b2b_words_in: got %0d expected 32", n_in - b_in); end
    checks++;
    if (n_out - b_out !== 12) begin errors++; $display("FAIL b2b_vecs_out: got %0d expected 12", n_out - b_out); end
  endtask

  task automatic test_downstream_stall();
    int b_in = n_in, b_out = n_out, b_done = n_done;
    int o, br;
    bit ok_a, ok;
    bus.ready_i = 1'b1;
    bus.valid_i = 1'b1;
    ok_a = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (n_out - b_out >= 2) begin ok_a = 1'b1; break; end
    end
    bus.ready_i = 1'b0;
    o  = n_out;
    br = bad_ready;
    repeat (20) tick();
    checks++;
    if (n_out !== o) begin errors++; $display("FAIL stall_out_frozen: got %0d expected %0d", n_out, o); end
    checks++;
    if (bad_ready !== br) begin errors++; $display("FAIL stall_layer_ready: got %0d expected %0d", bad_ready, br); end
    checks++;
    if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL stall_valid_pending: got %b expected 1", bus.valid_o); end
    checks++;
    if (n_in - b_in !== 16) begin errors++; $display("FAIL stall_words_in: got %0d expected 16", n_in - b_in); end
    bus.ready_i = 1'b1;
    wait_done(b_done + 1, 200, ok);
    bus.valid_i = 1'b0;
    tick();
    tick();
    checks++;
    if (!(ok_a && ok)) begin errors++; $display("FAIL stall_timeout: got %0d %0d expected 1 1", ok_a, ok); end
    checks++;
    if (n_out - b_out !== 6) begin errors++; $display("FAIL stall_vecs_out: got %0d expected 6", n_out - b_out); end
    checks++;
    if (last_data !== {NC{16'hA005}}) begin
      errors++;
      $display("FAIL stall_last_data: got %h expected %h", last_data, {NC{16'hA005}});
    end
  endtask

  task automatic test_extra_word();
    int b_in = n_in, b_done = n_done, b_start = n_start, b_by = bad_yumi;
    int in_at_done = -1;
    bit ok;
    bus.ready_i = 1'b1;
    bus.valid_i = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (in_at_done < 0 && n_done > b_done) in_at_done = n_in - b_in;
      if (n_in - b_in >= 17) begin
        bus.valid_i = 1'b0;
        ok = 1'b1;
        break;
      end
    end
    tick();
    checks++;
    if (!ok) begin errors++; $display("FAIL extra_timeout: got %0d words expected 17", n_in - b_in); end
    checks++;
    if (in_at_done !== 16) begin errors++; $display("FAIL extra_words_at_done: got %0d expected 16", in_at_done); end
    checks++;
    if (last_yumi_cyc <= last_start_cyc || n_start - b_start !== 2) begin
      errors++;
      $display("FAIL extra_word_after_start: got yumi_cyc %0d start_cyc %0d starts %0d expected yumi after start, 2 starts",
               last_yumi_cyc, last_start_cyc, n_start - b_start);
    end
    checks++;
    if (bad_yumi - b_by !== 0) begin errors++; $display("FAIL extra_gap_yumi: got %0d expected 0", bad_yumi - b_by); end
    apply_reset();
  endtask

  task automatic test_mid_frame_reset();
    int b_in = n_in, b_out, b_done, b_start;
    bit ok_a, ok;
    bus.ready_i = 1'b1;
    bus.valid_i = 1'b1;
    ok_a = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (n_in - b_in >= 7) begin ok_a = 1'b1; break; end
    end
    reset_i = 1'b1;
    tick();
    checks++;
    if ({busy_o, bus.yumi_o, error_o} !== 3'b000) begin
      errors++;
      $display("FAIL midreset_idle: got busy/yumi/error %b expected 000", {busy_o, bus.yumi_o, error_o});
    end
    reset_i = 1'b0;
    b_in    = n_in;
    b_out   = n_out;
    b_done  = n_done;
    b_start = n_start;
    wait_done(b_done + 1, 200, ok);
    bus.valid_i = 1'b0;
    tick();
    tick();
    checks++;
    if (!(ok_a && ok)) begin errors++; $display("FAIL midreset_timeout: got %0d %0d expected 1 1", ok_a, ok); end
    checks++;
    if (n_in - b_in !== 16 || n_out - b_out !== 6 || n_start - b_start !== 1) begin
      errors++;
      $display("FAIL midreset_fresh_frame: got in %0d out %0d starts %0d expected 16 6 1",
               n_in - b_in, n_out - b_out, n_start - b_start);
    end
  endtask

`ifdef CONV_SEQ_WATCHDOG_EN
  task automatic test_watchdog();
    int b_in, b_done, b_lrst;
    bit ok;
    apply_reset();
    b_in   = n_in;
    b_done = n_done;
    b_lrst = n_lrst;
    stall_mode  = 1'b1;
    bus.ready_i = 1'b1;
    bus.valid_i = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (n_lrst > b_lrst) begin ok = 1'b1; break; end
    end
    bus.valid_i = 1'b0;
    repeat (5) tick();
    checks++;
    if (!ok) begin errors++; $display("FAIL wd_timeout: no layer_reset_o within 100 cycles"); end
    checks++;
    if (n_in - b_in !== 5) begin errors++; $display("FAIL wd_words_in: got %0d expected 5", n_in - b_in); end
    checks++;
    if (lrst_cyc - last_yumi_cyc !== 16 || n_lrst - b_lrst !== 1) begin
      errors++;
      $display("FAIL wd_trip_cycle: got stall %0d pulses %0d expected 16 1", lrst_cyc - last_yumi_cyc, n_lrst - b_lrst);
    end
    checks++;
    if ({error_o, busy_o} !== 2'b10 || n_done - b_done !== 0) begin
      errors++;
      $display("FAIL wd_sticky: got error/busy %b done %0d expected 10 0", {error_o, busy_o}, n_done - b_done);
    end
    stall_mode = 1'b0;
    apply_reset();
    checks++;
    if (error_o !== 1'b0) begin errors++; $display("FAIL wd_error_clear: got %b expected 0", error_o); end
  endtask
`else
  task automatic test_tieoffs();
    checks++;
    if (n_lrst !== 0 || n_err_cyc !== 0) begin
      errors++;
      $display("FAIL tieoffs: got layer_reset %0d error cycles %0d expected 0 0", n_lrst, n_err_cyc);
    end
  endtask
`endif

  initial begin
    reset_i     = 1'b1;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_downstream_stall();
    test_extra_word();
    test_mid_frame_reset();
`ifdef CONV_SEQ_WATCHDOG_EN
    test_watchdog();
`else
    test_tieoffs();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded 20000 cycles");
    $fatal(1, "timeout");
  end
endmodule
